// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control FSM.
// States, opcode/funct values, ALU ops and datapath source selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_REX,
    S_RWB,
    S_IEX,
    S_IWB,
    S_BEQ,
    S_JMP,
    S_HALT
  } state_e;

  // ALU-decoder view of the current state
  typedef enum logic [2:0] {
    AC_NONE,
    AC_PC,
    AC_DEC,
    AC_MEM,
    AC_R,
    AC_I,
    AC_BEQ
  } acls_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;

  localparam logic [1:0] SA_PC    = 2'd0;
  localparam logic [1:0] SA_REGA  = 2'd1;
  localparam logic [1:0] SA_SHAMT = 2'd2;

  localparam logic [1:0] SB_REGB = 2'd0;
  localparam logic [1:0] SB_FOUR = 2'd1;
  localparam logic [1:0] SB_IMM  = 2'd2;
  localparam logic [1:0] SB_IMM4 = 2'd3;

  localparam logic [1:0] PS_ALU = 2'd0;
  localparam logic [1:0] PS_OUT = 2'd1;
  localparam logic [1:0] PS_JMP = 2'd2;

  function automatic logic op_legal(
    input logic [5:0] op
  );
    return (op == OP_RTYPE) || (op == OP_J)
        || (op == OP_BEQ)   || (op == OP_ADDI)
        || (op == OP_SLTI)  || (op == OP_LW)
        || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and zero flag in,
// every enable and select out. master = controller side.
interface multicycle_ctrl_if;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;

  logic       pc_en;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_src;
  logic       instr_done;
  logic       halted;

  modport master (
    input  opcode, funct, zero,
    output pc_en, iord, mem_read, mem_write,
    output ir_write, reg_dst, mem_to_reg, reg_write,
    output alu_src_a, alu_src_b, alu_op, pc_src,
    output instr_done, halted
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_en, iord, mem_read, mem_write,
    input  ir_write, reg_dst, mem_to_reg, reg_write,
    input  alu_src_a, alu_src_b, alu_op, pc_src,
    input  instr_done, halted
  );

endinterface

// File: rtl/ctrl_alu_dec.sv
// ALU op / operand-A decoder for the multicycle controller.
// In: state class, opcode, funct. Out: alu_op, alu_src_a, illegal.
module ctrl_alu_dec
  import ctrl_pkg::*;
(
  input  acls_e      cls_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o,
  output logic [1:0] alu_src_a_o,
  output logic       illegal_o
);

  always_comb begin
    alu_op_o    = ALU_ADD;
    alu_src_a_o = SA_PC;
    illegal_o   = 1'b0;
    unique case (cls_i)
      AC_DEC: begin
        illegal_o = !op_legal(opcode_i);
      end
      AC_MEM: begin
        alu_src_a_o = SA_REGA;
      end
      AC_R: begin
        alu_src_a_o = SA_REGA;
        unique case (1'b1)
          (funct_i == FN_ADD): alu_op_o = ALU_ADD;
          (funct_i == FN_SUB): alu_op_o = ALU_SUB;
          (funct_i == FN_AND): alu_op_o = ALU_AND;
          (funct_i == FN_OR):  alu_op_o = ALU_OR;
          (funct_i == FN_SLT): alu_op_o = ALU_SLT;
          (funct_i == FN_SLL): begin
            alu_op_o    = ALU_SLL;
            alu_src_a_o = SA_SHAMT;
          end
          default: illegal_o = 1'b1;
        endcase
      end
      AC_I: begin
        alu_src_a_o = SA_REGA;
        alu_op_o    = (opcode_i == OP_SLTI)
                    ? ALU_SLT : ALU_ADD;
      end
      AC_BEQ: begin
        alu_src_a_o = SA_REGA;
        alu_op_o    = ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle datapath.
// Ports: clk, rst_n (async, active low), bus (master modport).
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
)
(
  input logic              clk,
  input logic              rst_n,
  multicycle_ctrl_if.master bus
);

  localparam state_e ILL_NEXT =
    ILLEGAL_HALT ? S_HALT : S_FETCH;

  state_e state_q, state_d;
  // lw/sw choice captured in DECODE so
  // MEMADR does not look at the opcode again
  logic   store_q, store_d;

  acls_e  cls;
  logic   dec_ill;

  ctrl_alu_dec u_dec (
    .cls_i       (cls),
    .opcode_i    (bus.opcode),
    .funct_i     (bus.funct),
    .alu_op_o    (bus.alu_op),
    .alu_src_a_o (bus.alu_src_a),
    .illegal_o   (dec_ill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
    end
  end

  always_comb begin
    cls = AC_NONE;
    unique case (state_q)
      S_FETCH:  cls = AC_PC;
      S_DECODE: cls = AC_DEC;
      S_MEMADR: cls = AC_MEM;
      S_REX:    cls = AC_R;
      S_IEX:    cls = AC_I;
      S_BEQ:    cls = AC_BEQ;
      default:  cls = AC_NONE;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    store_d        = store_q;
    bus.pc_en      = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_b  = SB_REGB;
    bus.pc_src     = PS_ALU;
    bus.instr_done = 1'b0;
    bus.halted     = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.ir_write  = 1'b1;
        bus.alu_src_b = SB_FOUR;
        bus.pc_src    = PS_ALU;
        bus.pc_en     = 1'b1;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        bus.alu_src_b = SB_IMM4;
        unique case (1'b1)
          dec_ill:
            state_d = ILL_NEXT;
          (bus.opcode == OP_LW),
          (bus.opcode == OP_SW): begin
            state_d = S_MEMADR;
            store_d = (bus.opcode == OP_SW);
          end
          (bus.opcode == OP_RTYPE):
            state_d = S_REX;
          (bus.opcode == OP_BEQ):
            state_d = S_BEQ;
          (bus.opcode == OP_ADDI),
          (bus.opcode == OP_SLTI):
            state_d = S_IEX;
          (bus.opcode == OP_J):
            state_d = S_JMP;
          default:
            state_d = ILL_NEXT;
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_b = SB_IMM;
        state_d = store_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.iord     = 1'b1;
        bus.mem_read = 1'b1;
        state_d      = S_MEMWB;
      end
      S_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEMWR: begin
        bus.iord       = 1'b1;
        bus.mem_write  = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_REX: begin
        bus.alu_src_b = SB_REGB;
        state_d = dec_ill ? ILL_NEXT : S_RWB;
      end
      S_RWB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_IEX: begin
        bus.alu_src_b = SB_IMM;
        state_d       = S_IWB;
      end
      S_IWB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_BEQ: begin
        bus.alu_src_b  = SB_REGB;
        bus.pc_src     = PS_OUT;
        bus.pc_en      = bus.zero;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_JMP: begin
        bus.pc_src     = PS_JMP;
        bus.pc_en      = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_HALT: begin
        bus.halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore-style control FSM for the multicycle datapath. It issues the 3-bit ALU op and operand selects to the ALU and consumes the ALU zero flag for branches. It sequences the fetch, decode, execute, memory and writeback steps, and drives every datapath enable: PC, IR, memory and register file.

Parameters:
ILLEGAL_HALT, 1, 1: an unknown opcode or funct enters HALT; 0: it returns to FETCH, treating the instruction as a nop.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
pc_en  out  1  PC write enable, already combined with the branch condition
iord  out  1  memory address select: 0 PC, 1 ALUOut
mem_read  out  1  memory read
mem_write  out  1  memory write
ir_write  out  1  IR load
reg_dst  out  1  write register: 0 rt, 1 rd
mem_to_reg  out  1  write data: 0 ALUOut, 1 MDR
reg_write  out  1  register file write
alu_src_a  out  2  ALU a: 0 PC, 1 regA, 2 zero-extended shamt
alu_src_b  out  2  ALU b: 0 regB, 1 const 4, 2 sign-extended imm, 3 sign-extended imm<<2
alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 110 sll (computes b<<a)
pc_src  out  2  0 ALU result, 1 ALUOut, 2 jump target
instr_done  out  1  one-cycle pulse in each instruction's final state
halted  out  1  high while in HALT

Behaviour:
- Reset: the state goes asynchronously to IDLE. All outputs are 0 in IDLE. On the first clock edge after rst_n rises, the FSM moves to FETCH. Reset asserted in any state returns it to IDLE immediately.
- Outputs decode from state only, except pc_en in BEQ. Unlisted outputs are 0 in every state.
- FETCH: mem_read=1, ir_write=1, alu_src_a=0, alu_src_b=1, alu_op=add, pc_src=0, pc_en=1. Next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=add, which precomputes the branch target. Dispatch on opcode:
  - 100011 lw and 101011 sw -> MEMADR
  - 000000 R-type -> REX
  - 000100 beq -> BEQ
  - 001000 addi -> IEX
  - 001010 slti -> IEX
  - 000010 j -> JMP
  - anything else -> HALT if ILLEGAL_HALT=1, else FETCH
- MEMADR: alu_src_a=1, alu_src_b=2, add. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, mem_read=1 -> MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 -> FETCH.
- MEMWR: iord=1, mem_write=1, instr_done=1 -> FETCH.
- REX: alu_src_a=1, alu_src_b=0. alu_op comes from funct:
  - 100000 add
  - 100010 sub
  - 100100 and
  - 100101 or
  - 101010 slt
  - 000000 sll, with alu_src_a=2 instead
  - an unknown funct takes the same illegal path as an unknown opcode; no writeback occurs
  - Next state is RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
- IEX: alu_src_a=1, alu_src_b=2, alu_op=add for addi, slt for slti -> IWB.
- IWB: reg_write=1, reg_dst=0, instr_done=1 -> FETCH.
- BEQ: alu_src_a=1, alu_src_b=0, sub, pc_src=1, pc_en=zero, instr_done=1 -> FETCH.
- JMP: pc_src=2, pc_en=1, instr_done=1 -> FETCH.
- HALT: halted=1, all enables 0. The FSM stays in HALT until reset.
- Cycles per instruction, counted from FETCH: lw 5, sw 4, R-type 4, addi/slti 4, beq 3, j 3.
- The FSM holds the R-type or immediate ALU op for the full execute state, so the ALU sees a stable op.
- opcode and funct are sampled only in DECODE and in the REX/IEX decode. No other state uses them.

Decomposition:
- Shared package ctrl_pkg holds:
  - the state enum
  - opcode and funct localparams
  - ALU op localparams, matching the ALU encoding above
  - source-select localparams
- Sub-module ctrl_alu_dec decodes (state class, opcode, funct) into alu_op, alu_src_a and an illegal flag.

Test Plan:
- Reset held for 3 cycles, then released -> all outputs 0 while reset is low. One IDLE cycle, then FETCH with mem_read=ir_write=pc_en=1, alu_op=000, alu_src_b=1.
- opcode=100011 (lw) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles. MEMWB shows reg_write=1, mem_to_reg=1, and instr_done pulses exactly once.
- R-type with funct=000000 (sll) -> REX shows alu_src_a=2, alu_src_b=0, alu_op=110. RWB shows reg_dst=1, reg_write=1.
- beq run twice, with zero=1 then zero=0 in the BEQ state -> pc_en=1 with pc_src=1 on the first, pc_en=0 on the second. Each takes 3 cycles.
- opcode=111111 with ILLEGAL_HALT=1 -> halted=1 from the cycle after DECODE, no further enables. rst_n pulsed low mid-HALT -> IDLE immediately.
- rst_n asserted low during MEMWR -> mem_write drops to 0 asynchronously, with no extra instr_done pulse. After release, the FSM restarts at IDLE then FETCH.
